// File: rtl/tlv493_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlv493_pkg
//  Brief    : Shared state encoding, frame layout and bus defaults for the
//             TLV493D poll scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package tlv493_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_SELECT = 3'd1;
    localparam state_t c_ST_ADDR   = 3'd2;
    localparam state_t c_ST_READ   = 3'd3;
    localparam state_t c_ST_STORE  = 3'd4;
    localparam state_t c_ST_NEXT   = 3'd5;

    typedef logic [7:0] i2c_byte_t;

    localparam int c_NUM_BYTES = 6;
    typedef logic [c_NUM_BYTES-1:0][7:0] frame_t;

    // Byte positions inside the six-byte sensor readout frame
    localparam int c_B_BX_HI = 0;
    localparam int c_B_BY_HI = 1;
    localparam int c_B_BZ_HI = 2;
    localparam int c_B_XY_LO = 4;
    localparam int c_B_Z_LO  = 5;

    localparam i2c_byte_t c_I2C_RD_ADDR_DEFAULT = 8'hBD;

endpackage
`default_nettype wire

// File: rtl/tlv493_poll_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlv493_poll_scheduler_if
//  Brief    : Command/response handshake to the I2C byte master.
//  Revision : 1.0 - initial release
// ============================================================================
interface tlv493_poll_scheduler_if;
    import tlv493_pkg::*;

    logic      cmd_valid;
    logic      cmd_ready;
    logic      cmd_start;
    logic      cmd_stop;
    logic      cmd_read;
    i2c_byte_t cmd_wdata;
    logic      rsp_valid;
    i2c_byte_t rsp_data;
    logic      rsp_nack;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack
    );

endinterface
`default_nettype wire

// File: rtl/tlv493_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tlv493_unpack
//  Brief    : Combinational split of a six-byte readout into 12-bit Bx/By/Bz.
//  Revision : 1.0 - initial release
// ============================================================================
module tlv493_unpack
    import tlv493_pkg::*;
(
    input  frame_t             data,
    output logic signed [11:0] bx,
    output logic signed [11:0] by,
    output logic signed [11:0] bz
);

    assign bx = {data[c_B_BX_HI], data[c_B_XY_LO][7:4]};
    assign by = {data[c_B_BY_HI], data[c_B_XY_LO][3:0]};
    assign bz = {data[c_B_BZ_HI], data[c_B_Z_LO][3:0]};

endmodule
`default_nettype wire

// File: rtl/tlv493_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tlv493_poll_scheduler
//  Brief    : Periodically sweeps a muxed set of TLV493D sensors over a shared
//             I2C byte master and publishes each sensor's field vector.
//  Revision : 1.0 - initial release
// ============================================================================
module tlv493_poll_scheduler
    import tlv493_pkg::*;
#(
    parameter int        NUM_SENSORS   = 4,
    parameter int        SETTLE_CYCLES = 100,
    parameter int        SWEEP_PERIOD  = 50000,
    parameter i2c_byte_t I2C_RD_ADDR   = c_I2C_RD_ADDR_DEFAULT
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                enable,
    output logic [2:0]               sel,
    tlv493_poll_scheduler_if.master  bus,
    output logic                     res_valid,
    output logic [2:0]               res_sensor,
    output logic signed [11:0]       res_bx,
    output logic signed [11:0]       res_by,
    output logic signed [11:0]       res_bz,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int c_TW = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;
    localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TIMER_RELOAD = c_TW'(SWEEP_PERIOD - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST  = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]      c_LAST_IDX     = 3'(NUM_SENSORS - 1);

    state_t             r_state;
    logic [c_TW-1:0]    r_timer;
    logic [c_SW-1:0]    r_settle;
    logic [2:0]         r_idx;
    logic [2:0]         r_sel;
    logic [2:0]         r_byte;
    frame_t             r_bytes;
    logic               r_cmd_valid;
    logic               r_cmd_start;
    logic               r_cmd_stop;
    logic               r_cmd_read;
    i2c_byte_t          r_cmd_wdata;
    logic               r_res_valid;
    logic [2:0]         r_res_sensor;
    logic signed [11:0] r_res_bx;
    logic signed [11:0] r_res_by;
    logic signed [11:0] r_res_bz;
    logic [7:0]         r_err_count;

    logic signed [11:0] w_bx;
    logic signed [11:0] w_by;
    logic signed [11:0] w_bz;
    logic               w_rsp;

    tlv493_unpack u_unpack (
        .data (r_bytes),
        .bx   (w_bx),
        .by   (w_by),
        .bz   (w_bz)
    );

    // Only a response to an already-accepted command completes it
    assign w_rsp = bus.rsp_valid && !r_cmd_valid;

    // Free-running sweep timer; starts that land while busy are simply lost
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_timer == '0) begin
            r_timer <= c_TIMER_RELOAD;
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_settle     <= '0;
            r_idx        <= 3'd0;
            r_sel        <= 3'd0;
            r_byte       <= 3'd0;
            r_bytes      <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_start  <= 1'b0;
            r_cmd_stop   <= 1'b0;
            r_cmd_read   <= 1'b0;
            r_cmd_wdata  <= '0;
            r_res_valid  <= 1'b0;
            r_res_sensor <= 3'd0;
            r_res_bx     <= '0;
            r_res_by     <= '0;
            r_res_bz     <= '0;
            r_err_count  <= 8'd0;
        end else begin
            r_res_valid <= 1'b0;
            if (r_cmd_valid && bus.cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (enable && (r_timer == '0)) begin
                        r_idx    <= 3'd0;
                        r_sel    <= 3'd0;
                        r_settle <= '0;
                        r_state  <= c_ST_SELECT;
                    end
                end
                c_ST_SELECT: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_start <= 1'b1;
                        r_cmd_stop  <= 1'b0;
                        r_cmd_read  <= 1'b0;
                        r_cmd_wdata <= I2C_RD_ADDR;
                        r_state     <= c_ST_ADDR;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                c_ST_ADDR: begin
                    if (w_rsp) begin
                        if (bus.rsp_nack) begin
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state <= c_ST_NEXT;
                        end else begin
                            r_byte      <= 3'd0;
                            r_cmd_valid <= 1'b1;
                            r_cmd_start <= 1'b0;
                            r_cmd_stop  <= 1'b0;
                            r_cmd_read  <= 1'b1;
                            r_cmd_wdata <= '0;
                            r_state     <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    if (w_rsp) begin
                        r_bytes[r_byte] <= bus.rsp_data;
                        if (r_byte == 3'd5) begin
                            r_state <= c_ST_STORE;
                        end else begin
                            r_byte      <= r_byte + 3'd1;
                            r_cmd_valid <= 1'b1;
                            r_cmd_stop  <= (r_byte == 3'd4);
                        end
                    end
                end
                c_ST_STORE: begin
                    r_res_valid  <= 1'b1;
                    r_res_sensor <= r_idx;
                    r_res_bx     <= w_bx;
                    r_res_by     <= w_by;
                    r_res_bz     <= w_bz;
                    r_state      <= c_ST_NEXT;
                end
                c_ST_NEXT: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_idx    <= r_idx + 3'd1;
                        r_sel    <= r_idx + 3'd1;
                        r_settle <= '0;
                        r_state  <= c_ST_SELECT;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sel           = r_sel;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_start = r_cmd_start;
    assign bus.cmd_stop  = r_cmd_stop;
    assign bus.cmd_read  = r_cmd_read;
    assign bus.cmd_wdata = r_cmd_wdata;
    assign res_valid     = r_res_valid;
    assign res_sensor    = r_res_sensor;
    assign res_bx        = r_res_bx;
    assign res_by        = r_res_by;
    assign res_bz        = r_res_bz;
    assign err_count     = r_err_count;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
